pow_pipelined: RTL and testbench



---
 rtl/pow_pipelined_pkg.sv | 16 +
 rtl/pow_stage.sv | 66 ++++++
 rtl/pow_pipelined.sv | 81 ++++++++
 tb/tb_pow_pipelined.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pow_pipelined_pkg.sv
// Shared width helpers for the pipelined power unit.
//   out_width   : width of the final product x^POW.
//   stage_width : number of meaningful product bits after stage k, which holds x^(k+1).
package pow_pipelined_pkg;

  function automatic int unsigned out_width(input int unsigned data_width,
                                            input int unsigned pow);
    return data_width * pow;
  endfunction

  function automatic int unsigned stage_width(input int unsigned data_width,
                                              input int unsigned k);
    return data_width * (k + 1);
  endfunction

endpackage

// File: rtl/pow_stage.sv
// One register stage of the power pipeline.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid_i     : incoming beat valid from the previous stage (or the input port)
//   x_i         : operand copy travelling with the beat
//   p_i         : partial product from the previous stage (ignored when MULT == 0)
//   rdy_next_i  : readiness of the following stage (or the consumer)
//   rdy_o       : this stage can take a beat this cycle
//   valid_o, x_o, p_o : registered beat
// MULT == 0 is the first stage: the product register simply loads the operand.
module pow_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 40,
  parameter int unsigned MULT       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [OUT_WIDTH-1:0]  p_i,
  input  logic                  rdy_next_i,
  output logic                  rdy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] x_o,
  output logic [OUT_WIDTH-1:0]  p_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic [OUT_WIDTH-1:0]  p_q;
  logic [OUT_WIDTH-1:0]  x_ext;
  logic [OUT_WIDTH-1:0]  mul_a;
  logic [OUT_WIDTH-1:0]  p_d;

  always_comb begin
    x_ext                 = '0;
    x_ext[DATA_WIDTH-1:0] = x_i;
  end

  // First stage multiplies by one, which folds away to a plain load of the operand.
  assign mul_a = (MULT != 0) ? p_i : OUT_WIDTH'(1);
  // Product of x^k and x fits in OUT_WIDTH bits for every stage, so truncation is exact.
  assign p_d   = mul_a * x_ext;

  // Bubble collapsing: an empty stage is always ready, independent of downstream.
  assign rdy_o = !valid_q || rdy_next_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      p_q     <= '0;
    end else if (rdy_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        x_q <= x_i;
        p_q <= p_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign p_o     = p_q;

endmodule

// File: rtl/pow_pipelined.sv
// Pipelined integer power unit: out_data_o = in_data_i ** POW, one multiplier per stage.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o / in_data_i    : operand handshake
//   out_valid_o / out_ready_i / out_data_o : result handshake, exact POW*DATA_WIDTH-bit result
//   busy_o       : some stage holds a valid beat
// The ready chain is combinational from out_ready_i back to in_ready_o.
module pow_pipelined
  import pow_pipelined_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned POW        = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_WIDTH-1:0]     in_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [POW*DATA_WIDTH-1:0] out_data_o,
  output logic                      busy_o
);

  localparam int unsigned OUT_WIDTH = out_width(DATA_WIDTH, POW);

  logic [POW-1:0]        valid_s;
  logic [POW:0]          rdy_s;
  logic [DATA_WIDTH-1:0] x_s [POW];
  logic [OUT_WIDTH-1:0]  p_s [POW];

  assign rdy_s[POW] = out_ready_i;

  for (genvar k = 0; k < POW; k++) begin : g_stage
    logic                  v_in;
    logic [DATA_WIDTH-1:0] x_in;
    logic [OUT_WIDTH-1:0]  p_in;

    if (k == 0) begin : g_first
      assign v_in = in_valid_i;
      assign x_in = in_data_i;
      assign p_in = '0;
    end else begin : g_rest
      assign v_in = valid_s[k-1];
      assign x_in = x_s[k-1];
      assign p_in = p_s[k-1];
    end

    pow_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .MULT       ((k == 0) ? 0 : 1)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (v_in),
      .x_i        (x_in),
      .p_i        (p_in),
      .rdy_next_i (rdy_s[k+1]),
      .rdy_o      (rdy_s[k]),
      .valid_o    (valid_s[k]),
      .x_o        (x_s[k]),
      .p_o        (p_s[k])
    );

    // Stage k holds x^(k+1); nothing above that width may ever be set.
    localparam int unsigned SW = stage_width(DATA_WIDTH, k);
    a_stage_width : assert property (@(posedge clk) disable iff (!rst_n)
      valid_s[k] |-> ((p_s[k] >> SW) == '0));
  end

  // Operand copy leaving the last stage has no consumer.
  logic unused_last_x;
  assign unused_last_x = ^x_s[POW-1];

  assign in_ready_o  = rdy_s[0];
  assign out_valid_o = valid_s[POW-1];
  assign out_data_o  = p_s[POW-1];
  assign busy_o      = |valid_s;

endmodule

// File: tb/tb_pow_pipelined.sv
module tb_pow_pipelined;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 5;
  localparam int          NV = 10;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PW*DW-1:0]  out_data;
  logic              busy;

  int tests;
  int fails;

  typedef struct {
    logic [DW-1:0]    x;
    logic [PW*DW-1:0] y;
  } vec_t;

  vec_t        vecs [NV];
  logic [39:0] bp_exp [6];

  pow_pipelined #(
    .DATA_WIDTH (DW),
    .POW        (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [DW-1:0] x, input string name);
    in_valid = 1'b1;
    in_data  = x;
    #1;
    check(name, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int in_idx;
    int out_idx;
    int cyc;
    int stale;
    bit seen;

    tests = 0;
    fails = 0;

    vecs[0] = '{x: 8'd1,   y: 40'd1};
    vecs[1] = '{x: 8'd2,   y: 40'd32};
    vecs[2] = '{x: 8'd3,   y: 40'd243};
    vecs[3] = '{x: 8'd0,   y: 40'd0};
    vecs[4] = '{x: 8'd255, y: 40'd1078203909375};
    vecs[5] = '{x: 8'd7,   y: 40'd16807};
    vecs[6] = '{x: 8'd10,  y: 40'd100000};
    vecs[7] = '{x: 8'd16,  y: 40'd1048576};
    vecs[8] = '{x: 8'd128, y: 40'd34359738368};
    vecs[9] = '{x: 8'd200, y: 40'd320000000000};

    bp_exp[0] = 40'd32;
    bp_exp[1] = 40'd243;
    bp_exp[2] = 40'd1024;
    bp_exp[3] = 40'd3125;
    bp_exp[4] = 40'd7776;
    bp_exp[5] = 40'd16807;

    // Reset state
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_data", {24'd0, out_data}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat x=3, latency POW-1 edges after acceptance
    out_ready = 1'b1;
    push(8'd3, "single_in_ready");
    check("single_lat0", {63'd0, out_valid}, 64'd0);
    for (int i = 1; i < 4; i++) begin
      cycles(1);
      check("single_lat_early", {63'd0, out_valid}, 64'd0);
    end
    cycles(1);
    check("single_valid", {63'd0, out_valid}, 64'd1);
    check("single_data", {24'd0, out_data}, 64'd243);
    check("single_busy", {63'd0, busy}, 64'd1);
    cycles(1);
    check("single_valid_drop", {63'd0, out_valid}, 64'd0);
    check("single_busy_drop", {63'd0, busy}, 64'd0);

    // Back-to-back table stream with out_ready held high
    in_idx  = 0;
    out_idx = 0;
    cyc     = 0;
    while (out_idx < NV && cyc < 60) begin
      if (in_idx < NV) begin
        in_valid = 1'b1;
        in_data  = vecs[in_idx].x;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_idx < NV) begin
        check("stream_in_ready", {63'd0, in_ready}, 64'd1);
        if (in_ready) in_idx++;
      end
      if (out_valid) begin
        check($sformatf("stream_data[%0d]", out_idx), {24'd0, out_data},
              {24'd0, vecs[out_idx].y});
        out_idx++;
      end else if (out_idx > 0) begin
        check("stream_gap", {63'd0, out_valid}, 64'd1);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", 64'(out_idx), 64'(NV));
    cycles(1);
    check("stream_empty", {63'd0, busy}, 64'd0);

    // Backpressure: fill all five stages
    out_ready = 1'b0;
    push(8'd2, "bp_push0");
    push(8'd3, "bp_push1");
    push(8'd4, "bp_push2");
    push(8'd5, "bp_push3");
    push(8'd6, "bp_push4");
    check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_full_valid", {63'd0, out_valid}, 64'd1);
    check("bp_full_data", {24'd0, out_data}, 64'd32);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd7;
      #1;
      check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_hold_data", {24'd0, out_data}, 64'd32);
      @(posedge clk);
      #1;
    end
    // Full + consumer ready: pop and push in the same cycle
    out_ready = 1'b1;
    #1;
    check("bp_pop_push_ready", {63'd0, in_ready}, 64'd1);
    for (int j = 0; j < 6; j++) begin
      check($sformatf("bp_drain_valid[%0d]", j), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp_drain_data[%0d]", j), {24'd0, out_data}, {24'd0, bp_exp[j]});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #1;
    end
    check("bp_after_valid", {63'd0, out_valid}, 64'd0);
    check("bp_after_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;

    // Bubble collapse: second beat slides up behind a stalled first beat
    out_ready = 1'b0;
    push(8'd2, "bub_push0");
    cycles(10);
    push(8'd3, "bub_push1");
    cycles(5);
    check("bub_busy", {63'd0, busy}, 64'd1);
    check("bub_hold_data", {24'd0, out_data}, 64'd32);
    out_ready = 1'b1;
    #1;
    check("bub_out0_valid", {63'd0, out_valid}, 64'd1);
    check("bub_out0_data", {24'd0, out_data}, 64'd32);
    cycles(1);
    check("bub_out1_valid", {63'd0, out_valid}, 64'd1);
    check("bub_out1_data", {24'd0, out_data}, 64'd243);
    cycles(1);
    check("bub_done", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset with beats in flight
    out_ready = 1'b0;
    push(8'd4, "rst_push0");
    push(8'd5, "rst_push1");
    push(8'd6, "rst_push2");
    cycles(2);
    check("rst_pre_valid", {63'd0, out_valid}, 64'd1);
    check("rst_pre_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {63'd0, out_valid}, 64'd0);
    check("rst_async_busy", {63'd0, busy}, 64'd0);
    check("rst_async_data", {24'd0, out_data}, 64'd0);
    check("rst_async_in_ready", {63'd0, in_ready}, 64'd1);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'd0);

    // Recovery after reset
    push(8'd2, "rec_push");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        check("rec_data", {24'd0, out_data}, 64'd32);
      end else begin
        cycles(1);
      end
    end
    check("rec_seen", {63'd0, seen}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
